bus_access_arbiter: RTL and testbench

// - Shares the CPU's single memory bus port between instruction fetch (PC address) and

---
 rtl/bus_access_arbiter_if.sv | 46 ++++
 rtl/bus_access_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_bus_access_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_access_arbiter_if.sv
// Bundles the fetch requester, data requester and system bus signals of the
// memory-port arbiter. The master modport is the arbiter's view; slave is the environment's.
interface bus_access_arbiter_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_done;
  logic [31:0] fetch_rdata;
  logic        fetch_err;

  logic        data_req;
  logic        data_we;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_done;
  logic [31:0] data_rdata;
  logic        data_err;

  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    input  fetch_req, fetch_addr,
    output fetch_gnt, fetch_done, fetch_rdata, fetch_err,
    input  data_req, data_we, data_size, data_addr, data_wdata,
    output data_gnt, data_done, data_rdata, data_err,
    output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    output fetch_req, fetch_addr,
    input  fetch_gnt, fetch_done, fetch_rdata, fetch_err,
    output data_req, data_we, data_size, data_addr, data_wdata,
    input  data_gnt, data_done, data_rdata, data_err,
    input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/bus_access_arbiter.sv
// Shares one memory bus port between instruction fetch and data load/store:
// arbitration with fetch anti-starvation, lane generation, timed-out handshake, read alignment.
module bus_access_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_access_arbiter_if.master arb_io
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
  typedef enum logic       {OWN_FETCH, OWN_DATA}      owner_e;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  state_e            state_q;
  owner_e            owner_q;
  size_e             size_q;
  logic [1:0]        off_q;
  logic              we_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [STV_W-1:0]  starve_q;

  logic              bus_valid_q, bus_we_q;
  logic [31:0]       bus_addr_q, bus_wdata_q;
  logic [3:0]        bus_be_q;
  logic              fetch_gnt_q, fetch_done_q, fetch_err_q;
  logic [31:0]       fetch_rdata_q;
  logic              data_gnt_q, data_done_q, data_err_q;
  logic [31:0]       data_rdata_q;

  // Decode of the data request into lanes, replicated store data and fault.
  logic [1:0]  data_off;
  logic [3:0]  data_be;
  logic [31:0] data_wrep;
  logic        data_fault;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    data_off   = arb_io.data_addr[1:0];
    data_be    = 4'b0000;
    data_wrep  = '0;
    data_fault = 1'b0;
    case (size_e'(arb_io.data_size))
      SZ_BYTE: begin
        data_be   = 4'b0001 << data_off;
        data_wrep = {4{arb_io.data_wdata[7:0]}};
      end
      SZ_HALF: begin
        data_be    = 4'b0011 << data_off;
        data_wrep  = {2{arb_io.data_wdata[15:0]}};
        data_fault = data_off[0];
      end
      SZ_WORD: begin
        data_be    = 4'b1111;
        data_wrep  = arb_io.data_wdata;
        data_fault = (data_off != 2'b00);
      end
      default: data_fault = 1'b1;
    endcase
  end

  // Winner selection and the fields that get captured for it.
  logic        sel_fetch, sel_fault, sel_we;
  size_e       sel_size;
  logic [1:0]  sel_off;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_be;

  always_comb begin
    sel_fetch = arb_io.fetch_req && (!arb_io.data_req || (starve_q >= STV_MAX));
    if (sel_fetch) begin
      sel_fault = (arb_io.fetch_addr[1:0] != 2'b00);
      sel_we    = 1'b0;
      sel_size  = SZ_WORD;
      sel_off   = 2'b00;
      sel_addr  = {arb_io.fetch_addr[31:2], 2'b00};
      sel_be    = 4'b1111;
      sel_wdata = '0;
    end else begin
      sel_fault = data_fault;
      sel_we    = arb_io.data_we;
      sel_size  = size_e'(arb_io.data_size);
      sel_off   = data_off;
      sel_addr  = {arb_io.data_addr[31:2], 2'b00};
      sel_be    = data_be;
      sel_wdata = data_wrep;
    end
  end

  // Read data shifted down to bit 0 and zero-extended to the access size.
  logic [31:0] rd_shift, rd_align;

  always_comb begin
    rd_shift = arb_io.bus_rdata >> {off_q, 3'b000};
    case (size_q)
      SZ_BYTE: rd_align = {24'h0, rd_shift[7:0]};
      SZ_HALF: rd_align = {16'h0, rd_shift[15:0]};
      default: rd_align = rd_shift;
    endcase
  end

  // Completion: bus handshake, timeout expiry, or the delayed response of a faulted request.
  logic        done_now, done_err;
  logic [31:0] done_rdata;

  always_comb begin
    done_now   = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    case (state_q)
      S_ACCESS: begin
        if (arb_io.bus_ready) begin
          done_now   = 1'b1;
          done_rdata = we_q ? 32'h0 : rd_align;
        end else if (tmo_q == TMO_LAST) begin
          done_now = 1'b1;
          done_err = 1'b1;
        end
      end
      S_RESP: begin
        if (!(fetch_done_q || data_done_q)) begin
          done_now = 1'b1;
          done_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_q       <= OWN_FETCH;
      size_q        <= SZ_BYTE;
      off_q         <= 2'b00;
      we_q          <= 1'b0;
      tmo_q         <= '0;
      starve_q      <= '0;
      bus_valid_q   <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_be_q      <= '0;
      bus_wdata_q   <= '0;
      fetch_gnt_q   <= 1'b0;
      fetch_done_q  <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_rdata_q <= '0;
      data_gnt_q    <= 1'b0;
      data_done_q   <= 1'b0;
      data_err_q    <= 1'b0;
      data_rdata_q  <= '0;
    end else begin
      fetch_gnt_q  <= 1'b0;
      data_gnt_q   <= 1'b0;
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // A fetch loss is the only case that advances the starvation count.
          if (!arb_io.fetch_req || sel_fetch) starve_q <= '0;
          else                                starve_q <= starve_q + 1'b1;

          if (arb_io.fetch_req || arb_io.data_req) begin
            owner_q     <= sel_fetch ? OWN_FETCH : OWN_DATA;
            fetch_gnt_q <= sel_fetch;
            data_gnt_q  <= !sel_fetch;
            we_q        <= sel_we;
            size_q      <= sel_size;
            off_q       <= sel_off;
            tmo_q       <= '0;
            if (sel_fault) begin
              state_q <= S_RESP;
            end else begin
              state_q     <= S_ACCESS;
              bus_valid_q <= 1'b1;
              bus_we_q    <= sel_we;
              bus_addr_q  <= sel_addr;
              bus_be_q    <= sel_be;
              bus_wdata_q <= sel_wdata;
            end
          end
        end
        S_ACCESS: begin
          if (done_now) begin
            bus_valid_q <= 1'b0;
            state_q     <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_RESP: begin
          if (!done_now) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (done_now) begin
        if (owner_q == OWN_FETCH) begin
          fetch_done_q  <= 1'b1;
          fetch_rdata_q <= done_rdata;
          fetch_err_q   <= done_err;
        end else begin
          data_done_q  <= 1'b1;
          data_rdata_q <= done_rdata;
          data_err_q   <= done_err;
        end
      end
    end
  end

  assign arb_io.fetch_gnt   = fetch_gnt_q;
  assign arb_io.fetch_done  = fetch_done_q;
  assign arb_io.fetch_rdata = fetch_rdata_q;
  assign arb_io.fetch_err   = fetch_err_q;
  assign arb_io.data_gnt    = data_gnt_q;
  assign arb_io.data_done   = data_done_q;
  assign arb_io.data_rdata  = data_rdata_q;
  assign arb_io.data_err    = data_err_q;
  assign arb_io.bus_valid   = bus_valid_q;
  assign arb_io.bus_we      = bus_we_q;
  assign arb_io.bus_addr    = bus_addr_q;
  assign arb_io.bus_be      = bus_be_q;
  assign arb_io.bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_bus_access_arbiter.sv
// Self-checking bench for bus_access_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_bus_access_arbiter;

  localparam int TIMEOUT = 8;
  localparam int STARVE  = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: fetch losses in a row and the last response seen by each requester.
  int          m_losses = 0;
  logic [31:0] m_f_rdata = '0, m_d_rdata = '0;
  logic        m_f_err = 1'b0, m_d_err = 1'b0;
  logic        last_fetch_gnt;

  always #5 clk = ~clk;

  bus_access_arbiter_if arb_io ();

  bus_access_arbiter #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .STARVE_LIMIT   (STARVE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .arb_io (arb_io)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input int nbytes);
    return (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
  endfunction

  // Access size in bytes, alignment fault, byte enables and replicated store data.
  function automatic void model_lanes(input bit is_fetch, input logic [1:0] size,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      output bit fault, output int nbytes,
                                      output logic [3:0] be, output logic [31:0] wrep);
    int off;
    off    = int'(addr % 32'd4);
    nbytes = is_fetch ? 4 : ((size == 2'd3) ? 0 : (1 << size));
    be     = '0;
    wrep   = '0;
    if (nbytes == 0) begin
      fault = 1'b1;
    end else begin
      fault = (off % nbytes) != 0;
      be    = 4'(((1 << nbytes) - 1) << off);
      for (int i = 0; i < 4 / nbytes; i++)
        wrep = wrep | ((wdata & lane_mask(nbytes)) << (8 * nbytes * i));
    end
  endfunction

  // One arbitration round starting in an IDLE cycle; ends in the next IDLE cycle.
  // rdy_delay: cycles of bus_valid before bus_ready (negative = never).
  task automatic txn(input bit f_req, input logic [31:0] f_addr,
                     input bit d_req, input bit d_we, input logic [1:0] d_size,
                     input logic [31:0] d_addr, input logic [31:0] d_wdata,
                     input int rdy_delay, input logic [31:0] rdata);
    bit          fetch_wins, fault, timed_out, exp_we;
    int          nbytes, off;
    logic [3:0]  be;
    logic [31:0] wrep, a, exp_rdata;
    logic        exp_err;

    fetch_wins = f_req && (!d_req || m_losses >= STARVE);
    if (!f_req || fetch_wins) m_losses = 0;
    else                      m_losses++;

    a      = fetch_wins ? f_addr : d_addr;
    exp_we = fetch_wins ? 1'b0 : d_we;
    model_lanes(fetch_wins, d_size, a, d_wdata, fault, nbytes, be, wrep);
    off       = int'(a % 32'd4);
    timed_out = !fault && (rdy_delay < 0 || rdy_delay >= TIMEOUT);
    if (fault || timed_out) begin
      exp_rdata = '0;
      exp_err   = 1'b1;
    end else if (exp_we) begin
      exp_rdata = '0;
      exp_err   = 1'b0;
    end else begin
      exp_rdata = (rdata >> (8 * off)) & lane_mask(nbytes);
      exp_err   = 1'b0;
    end

    arb_io.fetch_req  = f_req;
    arb_io.fetch_addr = f_addr;
    arb_io.data_req   = d_req;
    arb_io.data_we    = d_we;
    arb_io.data_size  = d_size;
    arb_io.data_addr  = d_addr;
    arb_io.data_wdata = d_wdata;
    @(negedge clk);
    last_fetch_gnt = arb_io.fetch_gnt;
    check("fetch_gnt", arb_io.fetch_gnt, fetch_wins);
    check("data_gnt", arb_io.data_gnt, !fetch_wins);
    check("bus_valid_at_gnt", arb_io.bus_valid, !fault);
    arb_io.fetch_req = 1'b0;
    arb_io.data_req  = 1'b0;

    if (!fault) begin
      check("bus_addr", arb_io.bus_addr, a - (a % 32'd4));
      check("bus_be", arb_io.bus_be, be);
      check("bus_we", arb_io.bus_we, exp_we);
      if (exp_we) check("bus_wdata", arb_io.bus_wdata, wrep);
      for (int k = 0; k < TIMEOUT; k++) begin
        if (k == rdy_delay) begin
          arb_io.bus_ready = 1'b1;
          arb_io.bus_rdata = rdata;
        end
        @(negedge clk);
        arb_io.bus_ready = 1'b0;
        arb_io.bus_rdata = $urandom;
        if (k == rdy_delay || k == TIMEOUT - 1) break;
        check("bus_valid_hold", arb_io.bus_valid, 1'b1);
        check("bus_addr_hold", arb_io.bus_addr, a - (a % 32'd4));
      end
    end else begin
      @(negedge clk);
    end

    if (fetch_wins) begin
      m_f_rdata = exp_rdata;
      m_f_err   = exp_err;
    end else begin
      m_d_rdata = exp_rdata;
      m_d_err   = exp_err;
    end
    check("fetch_done", arb_io.fetch_done, fetch_wins);
    check("data_done", arb_io.data_done, !fetch_wins);
    check("bus_valid_at_done", arb_io.bus_valid, 1'b0);
    check("fetch_rdata", arb_io.fetch_rdata, m_f_rdata);
    check("fetch_err", arb_io.fetch_err, m_f_err);
    check("data_rdata", arb_io.data_rdata, m_d_rdata);
    check("data_err", arb_io.data_err, m_d_err);

    @(negedge clk);
    check("done_is_pulse", {30'b0, arb_io.fetch_done, arb_io.data_done}, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fetch"}, {arb_io.fetch_gnt, arb_io.fetch_done, arb_io.fetch_err}, 32'h0);
    check({tag, "_fetch_rdata"}, arb_io.fetch_rdata, 32'h0);
    check({tag, "_data"}, {arb_io.data_gnt, arb_io.data_done, arb_io.data_err}, 32'h0);
    check({tag, "_data_rdata"}, arb_io.data_rdata, 32'h0);
    check({tag, "_bus_ctl"}, {arb_io.bus_valid, arb_io.bus_we, arb_io.bus_be}, 32'h0);
    check({tag, "_bus_addr"}, arb_io.bus_addr, 32'h0);
    check({tag, "_bus_wdata"}, arb_io.bus_wdata, 32'h0);
  endtask

  bit exp_fetch_pat [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    reset             = 1'b1;
    arb_io.fetch_req  = 1'b0;
    arb_io.fetch_addr = '0;
    arb_io.data_req   = 1'b0;
    arb_io.data_we    = 1'b0;
    arb_io.data_size  = 2'b00;
    arb_io.data_addr  = '0;
    arb_io.data_wdata = '0;
    arb_io.bus_ready  = 1'b0;
    arb_io.bus_rdata  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Fetch, ready in the grant cycle.
    txn(1, 32'h100, 0, 0, 2'b10, 32'h0, 32'h0, 0, 32'hDEADBEEF);
    check("t_fetch_rdata", arb_io.fetch_rdata, 32'hDEADBEEF);

    // Byte load from the top lane.
    txn(0, 32'h0, 1, 0, 2'b00, 32'h203, 32'h0, 0, 32'hAB112233);
    check("t_lb_rdata", arb_io.data_rdata, 32'h0000_00AB);

    // Half store to the upper half.
    txn(0, 32'h0, 1, 1, 2'b01, 32'h402, 32'h0000_1234, 0, 32'h5555_5555);
    check("t_sh_rdata", arb_io.data_rdata, 32'h0);

    // Misaligned word load faults without touching the bus.
    txn(0, 32'h0, 1, 0, 2'b10, 32'h101, 32'h0, 0, 32'h0);
    check("t_fault_err", arb_io.data_err, 1'b1);

    // Both requesters held: data wins until fetch has lost STARVE times.
    for (int i = 0; i < 6; i++) begin
      txn(1, 32'h500 + 32'(4 * i), 1, 0, 2'b10, 32'h600 + 32'(4 * i), 32'h0, 0, $urandom);
      check("starve_pattern", last_fetch_gnt, exp_fetch_pat[i]);
    end

    // Bus never ready: timeout after TIMEOUT cycles of bus_valid.
    txn(1, 32'h700, 0, 0, 2'b10, 32'h0, 32'h0, -1, 32'h1234_5678);
    check("t_timeout_err", arb_io.fetch_err, 1'b1);

    // Late ready, half load from the upper half, and a reserved size.
    txn(0, 32'h0, 1, 0, 2'b01, 32'h802, 32'h0, 3, 32'hCAFE_F00D);
    check("t_lh_rdata", arb_io.data_rdata, 32'h0000_CAFE);
    txn(0, 32'h0, 1, 0, 2'b11, 32'h900, 32'h0, 0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      bit          f, d, we;
      logic [31:0] faddr, daddr, wdata, rdata;
      logic [1:0]  sz;
      int          r, dly;
      f     = 1'($urandom_range(0, 1));
      d     = 1'($urandom_range(0, 1));
      if (!f && !d) d = 1'b1;
      faddr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) faddr = faddr | 32'h1;
      daddr = $urandom;
      sz    = 2'($urandom_range(0, 3));
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      rdata = $urandom;
      r     = int'($urandom_range(0, 9));
      dly   = (r == 0) ? -1 : (r % 4);
      txn(f, faddr, d, we, sz, daddr, wdata, dly, rdata);
    end

    // Reset in the middle of an access: outputs drop at once, no done follows.
    arb_io.fetch_req  = 1'b1;
    arb_io.fetch_addr = 32'h300;
    @(negedge clk);
    check("mid_gnt", arb_io.fetch_gnt, 1'b1);
    check("mid_valid", arb_io.bus_valid, 1'b1);
    arb_io.fetch_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    reset     = 1'b0;
    m_losses  = 0;
    m_f_rdata = '0;
    m_d_rdata = '0;
    m_f_err   = 1'b0;
    m_d_err   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_reset_quiet", {arb_io.fetch_done, arb_io.data_done, arb_io.bus_valid}, 32'h0);
    end

    // Normal operation after reset.
    txn(1, 32'h40, 1, 0, 2'b00, 32'h41, 32'h0, 1, 32'h7766_5544);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
